// File: rtl/crossbar_feedback_return_if.sv
// Purpose: stream bundle between the crossbar and its return-path controller.
// Latency: none; this file holds wires only.
// Backpressure: s_valid/s_ready on the crossbar output stream, fb_valid/fb_ready on the feedback stream.
// Ports: s_data/s_valid/s_ready carry elements from the crossbar out_* port;
//        fb_data/fb_valid/fb_ready carry elements to the crossbar feedback_* port.
// The master modport is the return controller's view; slave is the crossbar/consumer view.
interface crossbar_feedback_return_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] fb_data;
    logic                  fb_valid;
    logic                  fb_ready;

    modport master (
        input  s_data,
        input  s_valid,
        input  fb_ready,
        output s_ready,
        output fb_data,
        output fb_valid
    );

    modport slave (
        output s_data,
        output s_valid,
        output fb_ready,
        input  s_ready,
        input  fb_data,
        input  fb_valid
    );
endinterface

// File: rtl/crossbar_feedback_return.sv
// Purpose: collect a vector from the crossbar output stream into a buffer, then replay it onto the feedback input.
// Latency: 1 cycle start->s_ready, 1 cycle last collect beat->fb_valid; 2*len+2 cycles per transaction.
// Backpressure: s_ready is high for exactly len beats; replay holds fb_data/fb_valid while fb_ready is low.
// Ports: clk, rst_n (async active-low); start/vec_len/abort control; xb stream bundle (master view);
//        cfg_sel (00 idle, 10 processing, 11 feedback), busy, done (1-cycle pulse), count (buffer occupancy).
// Every output comes from a register or from decoding the registered state.
module crossbar_feedback_return #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [LEN_W-1:0]                  vec_len,
    input  logic                              abort,
    crossbar_feedback_return_if.master        xb,
    output logic [1:0]                        cfg_sel,
    output logic                              busy,
    output logic                              done,
    output logic [LEN_W-1:0]                  count
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPLAY  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_W-1:0]       len;
    logic [LEN_W-1:0]       start_len;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic [DATA_WIDTH-1:0]  fb_data_q;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   collect_last;
    logic                   replay_last;

    assign start_len    = (vec_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : vec_len;
    assign collect_last = (count + LEN_W'(1)) == len;
    assign replay_last  = count == LEN_W'(1);

    // Stream handshakes and mode select decode straight from the state register.
    assign xb.s_ready  = (state == COLLECT);
    assign xb.fb_valid = (state == REPLAY);
    assign xb.fb_data  = fb_data_q;
    assign busy        = (state != IDLE);

    always_comb begin
        cfg_sel = 2'b00;
        case (state)
            COLLECT: cfg_sel = 2'b10;
            REPLAY:  cfg_sel = 2'b11;
            default: cfg_sel = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && (start_len != '0)) state_nxt = COLLECT;
                COLLECT: if (xb.s_valid && collect_last) state_nxt = REPLAY;
                REPLAY:  if (xb.fb_ready && replay_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Buffer storage carries no reset; only the indices define what is valid.
    always_ff @(posedge clk) begin
        if ((state == COLLECT) && xb.s_valid && !abort) begin
            mem[wr_idx] <= xb.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            count     <= '0;
            fb_data_q <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                wr_idx    <= '0;
                rd_idx    <= '0;
                count     <= '0;
                fb_data_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            len    <= start_len;
                            wr_idx <= '0;
                            rd_idx <= '0;
                            count  <= '0;
                            done   <= (start_len == '0);
                        end
                    end
                    COLLECT: begin
                        if (xb.s_valid) begin
                            wr_idx <= wr_idx + IDX_W'(1);
                            count  <= count + LEN_W'(1);
                            // Preload the first replay element; when len==1 it is
                            // being written this very cycle, so bypass the buffer.
                            if (collect_last) begin
                                fb_data_q <= (wr_idx == rd_idx) ? xb.s_data : mem[rd_idx];
                            end
                        end
                    end
                    REPLAY: begin
                        if (xb.fb_ready) begin
                            rd_idx <= rd_idx + IDX_W'(1);
                            count  <= count - LEN_W'(1);
                            if (replay_last) begin
                                done      <= 1'b1;
                                fb_data_q <= '0;
                            end else begin
                                fb_data_q <= mem[rd_idx + IDX_W'(1)];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_crossbar_feedback_return.sv
// Purpose: directed, table-driven check of the crossbar return-path controller.
// Latency: one vector per clock; outputs sampled 1 time unit after each rising edge.
// Backpressure: fb_ready and s_valid patterns are part of each vector.
module tb_crossbar_feedback_return;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vec_len = 4'd0;
    logic       abort = 1'b0;
    logic [1:0] cfg_sel;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int n_pass = 0;
    int n_total = 0;

    crossbar_feedback_return_if #(.DATA_WIDTH(16)) xb ();

    crossbar_feedback_return #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .vec_len (vec_len),
        .abort   (abort),
        .xb      (xb),
        .cfg_sel (cfg_sel),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Expected output word: {s_ready, fb_valid, fb_data, cfg_sel, busy, done, count}
    typedef struct {
        string       tag;
        logic        start;
        logic [3:0]  vlen;
        logic        abort;
        logic        sv;
        logic [15:0] sd;
        logic        fbr;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [25:0] e_idle(logic d);
        return {1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, d, 4'd0};
    endfunction

    function automatic logic [25:0] e_col(logic [3:0] c);
        return {1'b1, 1'b0, 16'h0000, 2'b10, 1'b1, 1'b0, c};
    endfunction

    function automatic logic [25:0] e_rep(logic [15:0] d, logic [3:0] c);
        return {1'b0, 1'b1, d, 2'b11, 1'b1, 1'b0, c};
    endfunction

    function automatic vec_t mk(string tag, logic st, logic [3:0] vl, logic ab, logic sv,
                                logic [15:0] sd, logic fbr, logic [25:0] exp);
        vec_t v;
        v.tag = tag; v.start = st; v.vlen = vl; v.abort = ab;
        v.sv = sv; v.sd = sd; v.fbr = fbr; v.exp = exp;
        return v;
    endfunction

    function automatic logic [25:0] actual();
        return {xb.s_ready, xb.fb_valid, xb.fb_data, cfg_sel, busy, done, count};
    endfunction

    task automatic check(string tag, logic [25:0] exp);
        logic [25:0] act;
        act = actual();
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {srdy,fbv,fbd,cfg,busy,done,cnt}=%b,%b,%h,%b,%b,%b,%0d want %b,%b,%h,%b,%b,%b,%0d",
                     tag, act[25], act[24], act[23:8], act[7:6], act[5], act[4], act[3:0],
                     exp[25], exp[24], exp[23:8], exp[7:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, check the registered result.
    task automatic apply(vec_t v);
        start      = v.start;
        vec_len    = v.vlen;
        abort      = v.abort;
        xb.s_valid = v.sv;
        xb.s_data  = v.sd;
        xb.fb_ready = v.fbr;
        @(posedge clk);
        #1;
        check(v.tag, v.exp);
    endtask

    initial begin
        xb.s_valid = 1'b0;
        xb.s_data = 16'h0000;
        xb.fb_ready = 1'b0;

        // Basic: len 4, back-to-back, fb_ready high -> 10-cycle transaction
        tbl.push_back(mk("basic_start", 1, 4'd4, 0, 0, 16'h0000, 1, e_col(4'd0)));
        tbl.push_back(mk("basic_in1",   0, 4'd0, 0, 1, 16'h0011, 1, e_col(4'd1)));
        tbl.push_back(mk("basic_in2",   0, 4'd0, 0, 1, 16'h0022, 1, e_col(4'd2)));
        tbl.push_back(mk("basic_in3",   0, 4'd0, 0, 1, 16'h0033, 1, e_col(4'd3)));
        tbl.push_back(mk("basic_in4",   0, 4'd0, 0, 1, 16'h0044, 1, e_rep(16'h0011, 4'd4)));
        tbl.push_back(mk("basic_out1",  0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0022, 4'd3)));
        tbl.push_back(mk("basic_out2",  0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0033, 4'd2)));
        tbl.push_back(mk("basic_out3",  0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0044, 4'd1)));
        tbl.push_back(mk("basic_done",  0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b1)));
        tbl.push_back(mk("basic_quiet", 0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b0)));
        // Backpressure: gapped s_valid, toggling fb_ready
        tbl.push_back(mk("bp_start",  1, 4'd3, 0, 0, 16'h0000, 0, e_col(4'd0)));
        tbl.push_back(mk("bp_in1",    0, 4'd0, 0, 1, 16'h0A01, 0, e_col(4'd1)));
        tbl.push_back(mk("bp_gap1",   0, 4'd0, 0, 0, 16'hDEAD, 1, e_col(4'd1)));
        tbl.push_back(mk("bp_in2",    0, 4'd0, 0, 1, 16'h0A02, 0, e_col(4'd2)));
        tbl.push_back(mk("bp_gap2",   0, 4'd0, 0, 0, 16'hBEEF, 1, e_col(4'd2)));
        tbl.push_back(mk("bp_in3",    0, 4'd0, 0, 1, 16'h0A03, 0, e_rep(16'h0A01, 4'd3)));
        tbl.push_back(mk("bp_hold1",  0, 4'd0, 0, 1, 16'h0BAD, 0, e_rep(16'h0A01, 4'd3)));
        tbl.push_back(mk("bp_out1",   0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0A02, 4'd2)));
        tbl.push_back(mk("bp_hold2",  0, 4'd0, 0, 0, 16'h0000, 0, e_rep(16'h0A02, 4'd2)));
        tbl.push_back(mk("bp_out2",   0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0A03, 4'd1)));
        tbl.push_back(mk("bp_hold3",  0, 4'd0, 0, 0, 16'h0000, 0, e_rep(16'h0A03, 4'd1)));
        tbl.push_back(mk("bp_done",   0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b1)));
        tbl.push_back(mk("bp_quiet",  0, 4'd0, 0, 1, 16'h1234, 1, e_idle(1'b0)));
        // Zero length: done next cycle, never busy
        tbl.push_back(mk("zero_start", 1, 4'd0, 0, 0, 16'h0000, 0, e_idle(1'b1)));
        tbl.push_back(mk("zero_after", 0, 4'd0, 0, 0, 16'h0000, 0, e_idle(1'b0)));

        // Reset state, checked between edges while rst_n is low
        #12;
        check("reset_state", e_idle(1'b0));
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Clamp: vec_len 12 -> 8 beats; an extra offered beat is refused
        apply(mk("clamp_start", 1, 4'd12, 0, 0, 16'h0000, 0, e_col(4'd0)));
        for (int i = 0; i < 8; i++) begin
            apply(mk("clamp_in", 0, 4'd0, 0, 1, 16'h0100 + 16'(i), 0,
                     (i == 7) ? e_rep(16'h0100, 4'd8) : e_col(4'(i + 1))));
        end
        apply(mk("clamp_extra", 0, 4'd0, 0, 1, 16'h0F0F, 0, e_rep(16'h0100, 4'd8)));
        for (int i = 0; i < 8; i++) begin
            apply(mk("clamp_out", 0, 4'd0, 0, 0, 16'h0000, 1,
                     (i == 7) ? e_idle(1'b1) : e_rep(16'h0101 + 16'(i), 4'(7 - i))));
        end
        apply(mk("clamp_quiet", 0, 4'd0, 0, 0, 16'h0000, 0, e_idle(1'b0)));

        // Abort after 2 of 5 beats (abort beat itself not counted), then a fresh len-2 run
        apply(mk("abort_start", 1, 4'd5, 0, 0, 16'h0000, 0, e_col(4'd0)));
        apply(mk("abort_in1",   0, 4'd0, 0, 1, 16'h0B01, 0, e_col(4'd1)));
        apply(mk("abort_in2",   0, 4'd0, 0, 1, 16'h0B02, 0, e_col(4'd2)));
        apply(mk("abort_hit",   1, 4'd3, 1, 1, 16'h0B03, 0, e_idle(1'b0)));
        apply(mk("abort_idle",  0, 4'd0, 0, 0, 16'h0000, 0, e_idle(1'b0)));
        apply(mk("abort_re",    1, 4'd2, 0, 0, 16'h0000, 0, e_col(4'd0)));
        apply(mk("abort_rin1",  0, 4'd0, 0, 1, 16'h0C01, 0, e_col(4'd1)));
        apply(mk("abort_rin2",  0, 4'd0, 0, 1, 16'h0C02, 1, e_rep(16'h0C01, 4'd2)));
        apply(mk("abort_rout1", 0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0C02, 4'd1)));
        apply(mk("abort_rdone", 0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b1)));

        // Start while busy is ignored
        apply(mk("busy_start", 1, 4'd3, 0, 0, 16'h0000, 0, e_col(4'd0)));
        apply(mk("busy_in1",   0, 4'd0, 0, 1, 16'h0D01, 0, e_col(4'd1)));
        apply(mk("busy_in2",   0, 4'd0, 0, 1, 16'h0D02, 0, e_col(4'd2)));
        apply(mk("busy_in3",   0, 4'd0, 0, 1, 16'h0D03, 0, e_rep(16'h0D01, 4'd3)));
        apply(mk("busy_restart", 1, 4'd7, 0, 0, 16'h0000, 1, e_rep(16'h0D02, 4'd2)));
        apply(mk("busy_out2",  0, 4'd0, 0, 0, 16'h0000, 1, e_rep(16'h0D03, 4'd1)));
        apply(mk("busy_done",  0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b1)));
        apply(mk("busy_idle1", 0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b0)));
        apply(mk("busy_idle2", 0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b0)));

        // Async reset mid-replay, between edges
        apply(mk("rst_start", 1, 4'd2, 0, 0, 16'h0000, 0, e_col(4'd0)));
        apply(mk("rst_in1",   0, 4'd0, 0, 1, 16'h0E01, 0, e_col(4'd1)));
        apply(mk("rst_in2",   0, 4'd0, 0, 1, 16'h0E02, 0, e_rep(16'h0E01, 4'd2)));
        start = 1'b0; abort = 1'b0; xb.s_valid = 1'b0; xb.fb_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_async", e_idle(1'b0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_held", e_idle(1'b0));
        // Clean restart, also covers len 1
        apply(mk("rst_re",    1, 4'd1, 0, 0, 16'h0000, 0, e_col(4'd0)));
        apply(mk("rst_rin",   0, 4'd0, 0, 1, 16'h0E05, 0, e_rep(16'h0E05, 4'd1)));
        apply(mk("rst_rout",  0, 4'd0, 0, 0, 16'h0000, 1, e_idle(1'b1)));
        apply(mk("rst_quiet", 0, 4'd0, 0, 0, 16'h0000, 0, e_idle(1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
